// File: rtl/mgmt_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the user-project bus.
// Build option: define MGMT_WB_ARB_TIMEOUT_EN to enable the no-ack watchdog.
module mgmt_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_owner;
  logic   w_own_cyc;
  logic   w_own_stb;
  logic   w_fire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mgmt_wb_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  assign grant    = r_state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign w_own_cyc = (r_state == GNT0) ? m0_cyc_i :
                     (r_state == GNT1) ? m1_cyc_i : 1'b0;
  assign w_own_stb = (r_state == GNT0) ? m0_stb_i :
                     (r_state == GNT1) ? m1_stb_i : 1'b0;

`ifdef MGMT_WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_timer;

  // An ack arriving in the terminal cycle wins over the watchdog.
  assign w_fire = w_own_cyc && w_own_stb && !s_ack_i && (r_timer == TO_LAST);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_timer <= '0;
    end else if (!w_own_cyc || s_ack_i || w_fire) begin
      r_timer <= '0;
    end else if (w_own_stb) begin
      r_timer <= r_timer + 16'd1;
    end
  end
`else
  assign w_fire = 1'b0;
`endif

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == GNT0) r_last_owner <= 1'b0;
      if (r_state == GNT1) r_last_owner <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last_owner ? GNT0 : GNT1;
        else if (m0_cyc_i)        w_next = GNT0;
        else if (m1_cyc_i)        w_next = GNT1;
      end
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_fire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_fire;
        if (!m0_cyc_i) w_next = IDLE;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_fire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_fire;
        if (!m1_cyc_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
